// File: rtl/xor_descrambler_pkg.sv
// Shared definitions for the additive (XOR/LFSR) scrambler and descrambler pair.
// The transmit scrambler and the receive descrambler must use the same
// polynomial and seed. Both sides import this package to get them.
//   SCR_POLY16       : Galois tap mask for x^16+x^14+x^13+x^11+1
//   SCR_SEED16       : reseed value loaded at every start-of-frame
//   lfsr_galois_step : one right-shifting Galois step. It works on a
//                      zero-extended state of up to LFSR_MAX_W bits.
package xor_descrambler_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  localparam logic [15:0] SCR_POLY16 = 16'hB400;
  localparam logic [15:0] SCR_SEED16 = 16'hACE1;

  // Narrower LFSRs are zero-extended. The right shift only brings zeros in
  // from the top, so the upper bits stay zero and the caller can truncate.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_galois_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly
  );
    logic [LFSR_MAX_W-1:0] s;
    s = state >> 1;
    if (state[0]) begin
      s = s ^ poly;
    end
    return s;
  endfunction

endpackage

// File: rtl/xor_descrambler_lfsr_nstep.sv
// lfsr_nstep: combinational N-step advance of an L-bit Galois LFSR.
// It is built as a chain of N single-step stages.
//   cur_i  [L-1:0] : state before advancing
//   next_o [L-1:0] : state after N Galois steps with tap mask POLY
module lfsr_nstep
  import xor_descrambler_pkg::*;
#(
  parameter int unsigned  L    = 16,
  parameter int unsigned  N    = 8,
  parameter logic [L-1:0] POLY = L'(SCR_POLY16)
) (
  input  logic [L-1:0] cur_i,
  output logic [L-1:0] next_o
);

  if (L > LFSR_MAX_W) begin : g_l_too_wide
    $error("lfsr_nstep: L exceeds LFSR_MAX_W");
  end
  if (N < 1) begin : g_n_zero
    $error("lfsr_nstep: N must be at least 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_step
    logic [L-1:0] s_in;
    logic [L-1:0] s_out;
    if (i == 0) begin : g_first
      assign s_in = cur_i;
    end else begin : g_chain
      assign s_in = g_step[i-1].s_out;
    end
    assign s_out = L'(lfsr_galois_step(LFSR_MAX_W'(s_in), LFSR_MAX_W'(POLY)));
  end

  assign next_o = g_step[N-1].s_out;

endmodule

// File: rtl/xor_descrambler.sv
// xor_descrambler: receive-side additive descrambler for byte streams.
// Each accepted beat is XORed with the next N LFSR keystream bits.
// The LFSR reseeds on in_sof or seed_load, so every frame decodes on its own.
// The output is a one-deep register slice with valid/ready on both sides.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   seed_load             : synchronous reseed of the LFSR to SEED
//   in_valid/in_ready     : input handshake; in_data is the scrambled beat,
//                           in_sof marks the first beat of a frame
//   out_valid/out_ready   : output handshake; out_data is the descrambled beat,
//                           out_sof is carried along with it
//   beat_cnt [CNTW-1:0]   : beats accepted since the last sof (the sof beat
//                           counts as 1); saturates at all-ones
module xor_descrambler
  import xor_descrambler_pkg::*;
#(
  parameter int unsigned  N    = 8,
  parameter int unsigned  L    = 16,
  parameter logic [L-1:0] POLY = L'(SCR_POLY16),
  parameter logic [L-1:0] SEED = L'(SCR_SEED16),
  parameter int unsigned  CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_load,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic            out_sof,
  output logic [CNTW-1:0] beat_cnt
);

  if (SEED == '0) begin : g_seed_zero
    $error("xor_descrambler: SEED must be nonzero");
  end
  if (N > L) begin : g_n_gt_l
    $error("xor_descrambler: N must not exceed L");
  end

  logic [L-1:0]    lfsr_q, lfsr_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_valid_q, out_valid_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

  logic            acc;
  logic [L-1:0]    cur;
  logic [L-1:0]    stepped;

  // The slot can take a new beat when it is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // A beat that starts a frame, or arrives with seed_load, decodes from SEED
  // directly. It does not wait for the register to reload.
  assign cur = (in_sof || seed_load) ? SEED : lfsr_q;

  lfsr_nstep #(
    .L    (L),
    .N    (N),
    .POLY (POLY)
  ) u_nstep (
    .cur_i  (cur),
    .next_o (stepped)
  );

  always_comb begin
    lfsr_d      = lfsr_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_valid_d = out_valid_q;
    beat_cnt_d  = beat_cnt_q;

    if (acc) begin
      // An all-zero state would lock the keystream at zero, so reseed instead.
      lfsr_d      = (stepped == '0) ? SEED : stepped;
      out_data_d  = in_data ^ cur[N-1:0];
      out_sof_d   = in_sof;
      out_valid_d = 1'b1;
      if (in_sof) begin
        beat_cnt_d = CNTW'(1);
      end else if (beat_cnt_q != {CNTW{1'b1}}) begin
        beat_cnt_d = beat_cnt_q + CNTW'(1);
      end
    end else begin
      if (seed_load) begin
        lfsr_d = SEED;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
